move_seq_ctrl: RTL and testbench

Turn-level move-entry controller for the chess screen. It sequences the four-phase move flow (player select, piece select, destination select, move validation) from debounced button pulses. It checks source-square ownership against the board RAM and hands the candidate move to the move validator over a req/ack handshake. On a legal move it emits a one-cycle commit to the board-update logic, and the display reads its cursor and phase outputs.

---
 rtl/move_seq_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_move_seq_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_seq_ctrl.sv
// Move-entry sequencer for the chess screen: cursor handling, source ownership check
// against board RAM, validator req/ack handshake with timeout, and commit/illegal pulses.
module move_seq_ctrl #(
  parameter int VAL_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       game_active,
  input  logic       new_game,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_sel,
  input  logic       btn_back,
  output logic [5:0] brd_rd_addr,
  input  logic [3:0] brd_rd_data,
  output logic       val_req,
  input  logic       val_ack,
  input  logic       val_legal,
  output logic [1:0] state,
  output logic       player,
  output logic [2:0] cursor_x,
  output logic [2:0] cursor_y,
  output logic [5:0] src_sq,
  output logic [5:0] dst_sq,
  output logic       commit,
  output logic       illegal
);

  localparam int CNT_W = $clog2(VAL_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VAL_TIMEOUT - 1);

  typedef enum logic [1:0] {
    PLAYER_SEL = 2'd0,
    PIECE_SEL  = 2'd1,
    POS_SEL    = 2'd2,
    MOVE_VAL   = 2'd3
  } move_state_t;

  move_state_t      state_q, state_d;
  logic             player_q, player_d;
  logic [2:0]       cx_q, cx_d, cy_q, cy_d;
  logic [2:0]       cx_mv, cy_mv;
  logic [5:0]       src_q, src_d, dst_q, dst_d;
  logic             req_q, req_d;
  logic             commit_q, commit_d;
  logic             illegal_q, illegal_d;
  logic             rd_pend_q, rd_pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       cursor_sq;

  assign cursor_sq = {cy_q, cx_q};

  // Direction pulses only; sel/back precedence is resolved in the FSM. 3-bit wrap gives modulo 8.
  always_comb begin
    cx_mv = cx_q;
    cy_mv = cy_q;
    if (btn_up)         cy_mv = cy_q + 3'd1;
    else if (btn_down)  cy_mv = cy_q - 3'd1;
    else if (btn_left)  cx_mv = cx_q - 3'd1;
    else if (btn_right) cx_mv = cx_q + 3'd1;
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d   = state_q;
    player_d  = player_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    src_d     = src_q;
    dst_d     = dst_q;
    req_d     = req_q;
    rd_pend_d = rd_pend_q;
    cnt_d     = cnt_q;
    commit_d  = 1'b0;
    illegal_d = 1'b0;

    if (!game_active) begin
      state_d   = PLAYER_SEL;
      req_d     = 1'b0;
      rd_pend_d = 1'b0;
    end else begin
      unique case (state_q)
        PLAYER_SEL: state_d = PIECE_SEL;
        PIECE_SEL: begin
          if (rd_pend_q) begin
            // brd_rd_data now reflects the square addressed when sel was pressed.
            rd_pend_d = 1'b0;
            if (brd_rd_data != 4'd0 && brd_rd_data[3] == player_q) begin
              src_d   = cursor_sq;
              state_d = POS_SEL;
            end else begin
              illegal_d = 1'b1;
            end
          end else if (btn_sel) begin
            rd_pend_d = 1'b1;
          end else if (!btn_back) begin
            cx_d = cx_mv;
            cy_d = cy_mv;
          end
        end
        POS_SEL: begin
          if (btn_sel) begin
            if (cursor_sq == src_q) begin
              state_d = PIECE_SEL;
            end else begin
              dst_d   = cursor_sq;
              req_d   = 1'b1;
              cnt_d   = '0;
              state_d = MOVE_VAL;
            end
          end else if (btn_back) begin
            state_d = PIECE_SEL;
          end else begin
            cx_d = cx_mv;
            cy_d = cy_mv;
          end
        end
        MOVE_VAL: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (val_ack) begin
            req_d = 1'b0;
            if (val_legal) begin
              commit_d = 1'b1;
              player_d = ~player_q;
              state_d  = PLAYER_SEL;
            end else begin
              illegal_d = 1'b1;
              state_d   = PIECE_SEL;
            end
          end else if (cnt_q == CNT_LAST) begin
            req_d     = 1'b0;
            illegal_d = 1'b1;
            state_d   = PIECE_SEL;
          end
        end
      endcase
    end

    // A new game wins over everything, including a same-cycle commit toggle.
    if (new_game) begin
      player_d  = 1'b0;
      state_d   = PLAYER_SEL;
      req_d     = 1'b0;
      rd_pend_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments only, so all flops update together.
  // NOTE: every register is reset here; none of this state is memory-like, so nothing is left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= PLAYER_SEL;
      player_q  <= 1'b0;
      cx_q      <= '0;
      cy_q      <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      req_q     <= 1'b0;
      commit_q  <= 1'b0;
      illegal_q <= 1'b0;
      rd_pend_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      player_q  <= player_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      req_q     <= req_d;
      commit_q  <= commit_d;
      illegal_q <= illegal_d;
      rd_pend_q <= rd_pend_d;
      cnt_q     <= cnt_d;
    end
  end

  assign brd_rd_addr = cursor_sq;
  assign val_req     = req_q;
  assign state       = state_q;
  assign player      = player_q;
  assign cursor_x    = cx_q;
  assign cursor_y    = cy_q;
  assign src_sq      = src_q;
  assign dst_sq      = dst_q;
  assign commit      = commit_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_move_seq_ctrl.sv
// Bench for move_seq_ctrl: directed move-flow scenarios followed by randomized buttons,
// board contents and validator behaviour, all compared each cycle to a square-level model.
module tb_move_seq_ctrl;

  localparam int VT = 8;

  logic       clk, rst_n;
  logic       game_active, new_game;
  logic       btn_up, btn_down, btn_left, btn_right, btn_sel, btn_back;
  logic [5:0] brd_rd_addr;
  logic [3:0] brd_rd_data;
  logic       val_req, val_ack, val_legal;
  logic [1:0] state;
  logic       player;
  logic [2:0] cursor_x, cursor_y;
  logic [5:0] src_sq, dst_sq;
  logic       commit, illegal;

  move_seq_ctrl #(.VAL_TIMEOUT(VT)) dut (
    .clk(clk), .rst_n(rst_n), .game_active(game_active), .new_game(new_game),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_sel(btn_sel), .btn_back(btn_back), .brd_rd_addr(brd_rd_addr),
    .brd_rd_data(brd_rd_data), .val_req(val_req), .val_ack(val_ack), .val_legal(val_legal),
    .state(state), .player(player), .cursor_x(cursor_x), .cursor_y(cursor_y),
    .src_sq(src_sq), .dst_sq(dst_sq), .commit(commit), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Board contents served by a one-cycle-latency RAM model.
  logic [3:0] board [64];

  // Reference model: phase 0..3 = player/piece/destination/validation, squares as rank*8+file.
  int         m_phase, m_player, m_cx, m_cy, m_src, m_dst, m_deadline, cyc;
  bit         m_req, m_commit, m_illegal, m_pend;
  logic [3:0] m_piece;

  bit auto_val = 0;
  int req_age, ack_delay;

  task automatic model_reset();
    m_phase = 0; m_player = 0; m_cx = 0; m_cy = 0; m_src = 0; m_dst = 0;
    m_req = 0; m_commit = 0; m_illegal = 0; m_pend = 0; m_deadline = -1;
  endtask

  task automatic model_move();
    if (btn_up)         m_cy = (m_cy + 1) % 8;
    else if (btn_down)  m_cy = (m_cy + 7) % 8;
    else if (btn_left)  m_cx = (m_cx + 7) % 8;
    else if (btn_right) m_cx = (m_cx + 1) % 8;
  endtask

  task automatic model_edge();
    int sq;
    sq = m_cy * 8 + m_cx;
    m_commit  = 0;
    m_illegal = 0;
    if (!game_active) begin
      m_phase = 0; m_req = 0; m_pend = 0;
    end else begin
      case (m_phase)
        0: m_phase = 1;
        1: begin
          if (m_pend) begin
            m_pend = 0;
            if (m_piece != 4'd0 && int'(m_piece[3]) == m_player) begin
              m_src = sq; m_phase = 2;
            end else m_illegal = 1;
          end else if (btn_sel) begin
            m_pend = 1; m_piece = board[sq];
          end else if (!btn_back) model_move();
        end
        2: begin
          if (btn_sel) begin
            if (sq == m_src) m_phase = 1;
            else begin
              m_dst = sq; m_req = 1; m_phase = 3; m_deadline = cyc + VT;
            end
          end else if (btn_back) m_phase = 1;
          else model_move();
        end
        default: begin
          if (val_ack) begin
            m_req = 0;
            if (val_legal) begin
              m_commit = 1; m_player = 1 - m_player; m_phase = 0;
            end else begin
              m_illegal = 1; m_phase = 1;
            end
          end else if (cyc == m_deadline) begin
            m_illegal = 1; m_req = 0; m_phase = 1;
          end
        end
      endcase
    end
    if (new_game) begin
      m_player = 0; m_phase = 0; m_req = 0; m_pend = 0;
    end
  endtask

  task automatic compare_all();
    check("state",    state,       m_phase);
    check("player",   player,      m_player);
    check("cursor_x", cursor_x,    m_cx);
    check("cursor_y", cursor_y,    m_cy);
    check("rd_addr",  brd_rd_addr, m_cy * 8 + m_cx);
    check("src_sq",   src_sq,      m_src);
    check("dst_sq",   dst_sq,      m_dst);
    check("val_req",  val_req,     m_req);
    check("commit",   commit,      m_commit);
    check("illegal",  illegal,     m_illegal);
  endtask

  task automatic drive_validator();
    val_legal = 1'($urandom_range(0, 1));
    if (val_req) begin
      req_age++;
      if (req_age == ack_delay) val_ack = 1'b1;
    end else begin
      req_age   = 0;
      ack_delay = $urandom_range(1, 10);
      if ($urandom_range(0, 49) == 0) val_ack = 1'b1;
    end
  endtask

  // One clock: DUT and model both consume the current inputs, then outputs are compared.
  task automatic step();
    logic [5:0] a;
    a = brd_rd_addr;
    @(posedge clk);
    #1;
    model_edge();
    cyc++;
    brd_rd_data = board[a];
    {btn_up, btn_down, btn_left, btn_right, btn_sel, btn_back, new_game, val_ack} = '0;
    compare_all();
    if (auto_val) drive_validator();
  endtask

  task automatic press_sel_and_read();
    btn_sel = 1'b1; step();
    step();
  endtask

  initial begin
    rst_n = 1'b0; game_active = 1'b0; new_game = 1'b0; val_ack = 1'b0; val_legal = 1'b0;
    {btn_up, btn_down, btn_left, btn_right, btn_sel, btn_back} = '0;
    brd_rd_data = 4'd0; cyc = 0; req_age = 0; ack_delay = 1;
    for (int i = 0; i < 64; i++) board[i] = 4'd0;
    board[6'o14] = 4'b0001;   // white pawn at e2
    board[6'o15] = 4'b1001;   // black pawn at f2
    model_reset();

    #12;
    check("rst_state", state, 0);
    check("rst_player", player, 0);
    check("rst_cursor", {cursor_y, cursor_x}, 0);
    check("rst_src_dst", {src_sq, dst_sq}, 0);
    check("rst_pulses", {val_req, commit, illegal}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Enter piece select and wrap the cursor left from file 0.
    game_active = 1'b1; step();
    btn_left = 1'b1; step();
    check("wrap_left_x", cursor_x, 7);
    check("wrap_left_state", state, 1);

    repeat (3) begin btn_left = 1'b1; step(); end
    btn_up = 1'b1; step();
    check("at_e2", {cursor_y, cursor_x}, 6'o14);

    // Black piece as white, then empty square: both rejected.
    btn_right = 1'b1; step();
    press_sel_and_read();
    check("black_illegal", illegal, 1);
    check("black_state", state, 1);
    repeat (2) begin btn_left = 1'b1; step(); end
    press_sel_and_read();
    check("empty_illegal", illegal, 1);
    check("empty_state", state, 1);

    // Own pawn accepted.
    btn_right = 1'b1; step();
    press_sel_and_read();
    check("own_src", src_sq, 6'o14);
    check("own_state", state, 2);

    // Destination e4, legal ack three cycles after sel.
    repeat (2) begin btn_up = 1'b1; step(); end
    btn_sel = 1'b1; step();
    check("req_up", val_req, 1);
    check("req_state", state, 3);
    check("dst", dst_sq, 6'o34);
    step(); step();
    val_ack = 1'b1; val_legal = 1'b1; step();
    check("commit_hi", commit, 1);
    check("commit_player", player, 1);
    check("commit_state", state, 0);
    check("commit_req_lo", val_req, 0);
    step();
    check("commit_lo", commit, 0);

    // Black picks f2, moves to f3, validator never answers.
    repeat (2) begin btn_down = 1'b1; step(); end
    btn_right = 1'b1; step();
    press_sel_and_read();
    check("black_src", src_sq, 6'o15);
    btn_up = 1'b1; step();
    btn_sel = 1'b1; step();
    for (int k = 0; k < VT - 1; k++) begin
      step();
      check("timeout_wait", illegal, 0);
    end
    step();
    check("timeout_illegal", illegal, 1);
    check("timeout_state", state, 1);
    check("timeout_req_lo", val_req, 0);

    // Selecting the source square again deselects without a request.
    btn_down = 1'b1; step();
    press_sel_and_read();
    btn_sel = 1'b1; step();
    check("deselect_state", state, 1);
    check("deselect_req", val_req, 0);

    // Abort during validation; the same-cycle ack is discarded.
    press_sel_and_read();
    btn_up = 1'b1; step();
    btn_sel = 1'b1; step();
    step();
    game_active = 1'b0; val_ack = 1'b1; val_legal = 1'b1; step();
    check("abort_req", val_req, 0);
    check("abort_state", state, 0);
    check("abort_player", player, 1);
    check("abort_commit", commit, 0);
    game_active = 1'b1; step();

    // new_game coincident with a legal ack forces white.
    btn_down = 1'b1; step();
    press_sel_and_read();
    btn_up = 1'b1; step();
    btn_sel = 1'b1; step();
    step();
    new_game = 1'b1; val_ack = 1'b1; val_legal = 1'b1; step();
    check("newgame_player", player, 0);
    check("newgame_state", state, 0);

    // Asynchronous reset in the middle of a handshake.
    step();
    btn_left = 1'b1; step();
    btn_down = 1'b1; step();
    press_sel_and_read();
    btn_up = 1'b1; step();
    btn_sel = 1'b1; step();
    step();
    check("pre_reset_req", val_req, 1);
    #3 rst_n = 1'b0;
    #1;
    check("async_req", val_req, 0);
    check("async_state", state, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized run.
    for (int i = 0; i < 64; i++)
      board[i] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
    auto_val = 1;
    for (int n = 0; n < 4000; n++) begin
      int r;
      r = $urandom_range(0, 99);
      game_active = ($urandom_range(0, 99) >= 3);
      new_game    = ($urandom_range(0, 99) == 0);
      if (r < 14)      btn_sel   = 1'b1;
      else if (r < 18) btn_back  = 1'b1;
      else if (r < 30) btn_up    = 1'b1;
      else if (r < 42) btn_down  = 1'b1;
      else if (r < 54) btn_left  = 1'b1;
      else if (r < 66) btn_right = 1'b1;
      else if (r < 72) begin
        btn_sel   = 1'($urandom_range(0, 1));
        btn_back  = 1'($urandom_range(0, 1));
        btn_up    = 1'($urandom_range(0, 1));
        btn_down  = 1'($urandom_range(0, 1));
        btn_left  = 1'($urandom_range(0, 1));
        btn_right = 1'($urandom_range(0, 1));
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
